// File: rtl/div_share_ctrl.sv
// Round-robin front end sharing one restoring divider (one quotient bit per clock) between two requesters.
// Response is registered and held until rsp_ready; no new request is accepted until the response is taken.
module div_share_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_dividend,
  input  logic [2*WIDTH-1:0] req_divisor,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_quotient,
  output logic [WIDTH-1:0]   rsp_remainder,
  output logic               rsp_dbz,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
  } op_t;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dbz;
  } rsp_t;

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic [WIDTH:0]  rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ptr_q, ptr_d;
  rsp_t            rsp_q, rsp_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            busy_q, busy_d;

  logic [1:0]       gnt;
  logic             gnt_id;
  logic [WIDTH-1:0] sel_dvd;
  logic [WIDTH-1:0] sel_dvs;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             qbit;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // Pointed requester wins a tie; pointer flips to the other side on every accept.
  always_comb begin
    gnt = 2'b00;
    if (state_q == IDLE && !rst) begin
      if (req_valid[ptr_q]) begin
        gnt[ptr_q] = 1'b1;
      end else if (req_valid[~ptr_q]) begin
        gnt[~ptr_q] = 1'b1;
      end
    end
  end

  assign gnt_id  = gnt[1];
  assign sel_dvd = gnt_id ? req_dividend[2*WIDTH-1:WIDTH] : req_dividend[WIDTH-1:0];
  assign sel_dvs = gnt_id ? req_divisor[2*WIDTH-1:WIDTH]  : req_divisor[WIDTH-1:0];

  // op_q.dvd doubles as the quotient register: dividend bits shift out, quotient bits shift in.
  assign shifted = {rem_q, op_q.dvd[WIDTH-1]};
  assign trial   = shifted - {2'b00, op_q.dvs};
  assign qbit    = ~trial[WIDTH+1];
  assign rem_nxt = qbit ? trial[WIDTH:0] : shifted[WIDTH:0];
  assign quo_nxt = {op_q.dvd[WIDTH-2:0], qbit};

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          op_d.id  = gnt_id;
          op_d.dvd = sel_dvd;
          op_d.dvs = sel_dvs;
          ptr_d    = ~gnt_id;
          if (sel_dvs == '0) begin
            rsp_d.id    = gnt_id;
            rsp_d.quo   = '1;
            rsp_d.rem   = sel_dvd;
            rsp_d.dbz   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            rem_d   = '0;
            cnt_d   = '0;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        rem_d    = rem_nxt;
        op_d.dvd = quo_nxt;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          rsp_d.id    = op_q.id;
          rsp_d.quo   = quo_nxt;
          rsp_d.rem   = rem_nxt[WIDTH-1:0];
          rsp_d.dbz   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready     = gnt;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_q.id;
  assign rsp_quotient  = rsp_q.quo;
  assign rsp_remainder = rsp_q.rem;
  assign rsp_dbz       = rsp_q.dbz;
  assign busy          = busy_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl: per-port request queues feed the DUT, a scoreboard
// holds the expected response of every accepted request until the response handshake.
module tb_div_share_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_dividend;
  logic [2*W-1:0] req_divisor;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [W-1:0]   rsp_quotient;
  logic [W-1:0]   rsp_remainder;
  logic           rsp_dbz;
  logic           busy;

  always #5 clk = ~clk;

  div_share_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_quotient (rsp_quotient),
    .rsp_remainder(rsp_remainder),
    .rsp_dbz      (rsp_dbz),
    .busy         (busy)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  typedef struct packed {
    logic         id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           acc;
  } exp_t;

  op_t  pq0[$];
  op_t  pq1[$];
  exp_t sb[$];
  int   gnt_exp[$];

  int   n_chk    = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rv_start = 0;
  int   last_acc = 0;
  int   rst_rel  = 0;
  logic rv_prev  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input op_t o, input int acc);
    exp_t e;
    e.id  = id;
    e.acc = acc;
    if (o.b == '0) begin
      e.q   = '1;
      e.r   = o.a;
      e.dbz = 1'b1;
    end else begin
      e.q   = o.a / o.b;
      e.r   = o.a % o.b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic push_op(input int port, input int a, input int b);
    op_t o;
    o.a = W'(a);
    o.b = W'(b);
    if (port == 0) pq0.push_back(o);
    else           pq1.push_back(o);
  endtask

  // Idle ports carry random operands so a wrong select shows up as a wrong result.
  task automatic drive();
    req_valid[0]           = (pq0.size() > 0);
    req_valid[1]           = (pq1.size() > 0);
    req_dividend[W-1:0]    = (pq0.size() > 0) ? pq0[0].a : W'($urandom);
    req_divisor[W-1:0]     = (pq0.size() > 0) ? pq0[0].b : W'($urandom);
    req_dividend[2*W-1:W]  = (pq1.size() > 0) ? pq1[0].a : W'($urandom);
    req_divisor[2*W-1:W]   = (pq1.size() > 0) ? pq1[0].b : W'($urandom);
  endtask

  // Observe at the negedge what the coming posedge will do, then step past it.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rsp_valid && !rv_prev) rv_start = cyc;
    rv_prev = rsp_valid;
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        op_t o;
        if (i == 0) o = pq0.pop_front();
        else        o = pq1.pop_front();
        sb.push_back(model(1'(i), o, cyc + 1));
        last_acc = cyc + 1;
        if (gnt_exp.size() > 0) check("grant_order", 32'(i), 32'(gnt_exp.pop_front()));
      end
    end
    if (rsp_valid && rsp_ready && sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_id", 32'(rsp_id), 32'(e.id));
      check("rsp_quotient", 32'(rsp_quotient), 32'(e.q));
      check("rsp_remainder", 32'(rsp_remainder), 32'(e.r));
      check("rsp_dbz", 32'(rsp_dbz), 32'(e.dbz));
      check("busy_in_done", 32'(busy), 32'd1);
      check("latency", 32'(rv_start - e.acc + 1), e.dbz ? 32'd1 : 32'(W + 1));
    end else if (sb.size() == 0) begin
      check("no_spurious_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() > 0 || pq0.size() > 0 || pq1.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(sb.size() + pq0.size() + pq1.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    exp_t h;
    rst          = 1'b1;
    rsp_ready    = 1'b1;
    req_valid    = 2'b00;
    req_dividend = '0;
    req_divisor  = '0;

    // Reset with a request already waiting on port 0.
    push_op(0, 42, 5);
    drive();
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_quotient", 32'(rsp_quotient), 32'd0);
    check("rst_rsp_remainder", 32'(rsp_remainder), 32'd0);
    check("rst_rsp_dbz", 32'(rsp_dbz), 32'd0);

    rst     = 1'b0;
    rst_rel = cyc;
    gnt_exp.push_back(0);
    wait_drain(40);
    check("first_accept_edge", 32'(last_acc), 32'(rst_rel + 1));

    // Divide by zero on port 1; leaves the pointer on port 0.
    push_op(1, 77, 0);
    drive();
    wait_drain(20);

    // Both ports contending: grants alternate, port 0 operands change right after accept.
    push_op(0, 123, 11);
    push_op(0, 54, 6);
    push_op(1, 255, 7);
    gnt_exp.push_back(0);
    gnt_exp.push_back(1);
    gnt_exp.push_back(0);
    drive();
    wait_drain(100);
    check("grant_order_done", 32'(gnt_exp.size()), 32'd0);

    // Operand edge cases.
    push_op(0, 0, 150);
    push_op(0, 100, 100);
    push_op(0, 255, 1);
    push_op(1, 255, 255);
    push_op(1, 254, 255);
    drive();
    wait_drain(150);

    // Stalled consumer: response must hold and no request may be accepted meanwhile.
    rsp_ready = 1'b0;
    push_op(0, 200, 7);
    drive();
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check("stall_rsp_seen", 32'(rsp_valid), 32'd1);
    push_op(1, 9, 2);
    drive();
    h = model(1'b0, op_t'({8'd200, 8'd7}), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_rsp_quotient", 32'(rsp_quotient), 32'(h.q));
      check("hold_rsp_remainder", 32'(rsp_remainder), 32'(h.r));
      check("hold_rsp_id", 32'(rsp_id), 32'(h.id));
      check("hold_rsp_dbz", 32'(rsp_dbz), 32'(h.dbz));
    end
    rsp_ready = 1'b1;
    tick();
    check("drop_after_ready", 32'(rsp_valid), 32'd0);
    wait_drain(40);

    // Reset in the 4th ITER cycle discards the operation and returns the pointer to port 0.
    push_op(0, 200, 3);
    drive();
    n = 0;
    while (sb.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    check("midrst_accepted", 32'(sb.size()), 32'd1);
    tick();
    tick();
    tick();
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    push_op(0, 50, 25);
    push_op(1, 10, 3);
    gnt_exp.push_back(0);
    gnt_exp.push_back(1);
    drive();
    wait_drain(60);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
